// File: rtl/div_pkg.sv
// Shared encodings and widths for the iterative divider.
package div_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and emits one quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  // The partial remainder is always below the divisor, so after the shift it
  // needs one extra bit, and the difference always fits back into XLEN bits.
  always_comb begin
    rem_sh = {rem_in, quo_in[XLEN-1]};
    ge     = (rem_sh >= {1'b0, divisor});
    diff   = rem_sh[XLEN-1:0] - divisor;
    if (ge) begin
      rem_out = diff;
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = rem_sh[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// 32-cycle restoring divider for DIV/DIVU/REM/REMU with sign fix-up,
// divide-by-zero and signed-overflow shortcuts, and pipeline stall/flush.
module div_sequencer
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            div_start,
  input  logic [2:0]      div_op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            div_busy,
  output logic            div_stall,
  output logic            div_done,
  output logic [XLEN-1:0] div_result,
  output logic [4:0]      div_rd
);

  state_t          state;
  logic [5:0]      count;
  logic            busy_q;
  logic            done_q;
  logic            is_rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;

  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;

  logic            accept;
  logic            is_signed;
  logic            is_rem;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] fix_quo;
  logic [XLEN-1:0] fix_rem;

  div_step u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    accept    = (state == IDLE) && div_start && !flush && div_op[2];
    is_signed = (div_op == OP_DIV) || (div_op == OP_REM);
    is_rem    = (div_op == OP_REM) || (div_op == OP_REMU);
    mag1      = (is_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
    mag2      = (is_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
    div_zero  = (rs2_val == '0);
    overflow  = is_signed && (rs1_val == INT_MIN) && (rs2_val == '1);
    if (div_zero)
      special_res = is_rem ? rs1_val : '1;
    else
      special_res = is_rem ? '0 : INT_MIN;
    // Fix-up is applied to the outputs of the final step, not the registers.
    fix_quo = neg_quo_q ? -step_quo : step_quo;
    fix_rem = neg_rem_q ? -step_rem : step_rem;
  end

  assign div_busy  = busy_q;
  assign div_done  = done_q && !flush;
  assign div_stall = accept || (state == CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      rd_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      div_result <= '0;
      div_rd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_rem_q  <= is_rem;
            neg_quo_q <= is_signed && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
            neg_rem_q <= is_signed && rs1_val[XLEN-1];
            rd_q      <= rd_in;
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= mag1;
            dvs_q     <= mag2;
            busy_q    <= 1'b1;
            if (div_zero || overflow) begin
              state      <= DONE;
              done_q     <= 1'b1;
              div_result <= special_res;
              div_rd     <= rd_in;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            count  <= '0;
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            count <= count + 6'd1;
            if (count == 6'd31) begin
              state      <= DONE;
              done_q     <= 1'b1;
              count      <= '0;
              div_result <= is_rem_q ? fix_rem : fix_quo;
              div_rd     <= rd_q;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, signed/unsigned results,
// special cases, flush, reset abort and ignored opcodes.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_start = 1'b0;
  logic [2:0]  div_op = 3'b000;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        div_busy;
  logic        div_stall;
  logic        div_done;
  logic [31:0] div_result;
  logic [4:0]  div_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_op     (div_op),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .rd_in      (rd_in),
    .flush      (flush),
    .div_busy   (div_busy),
    .div_stall  (div_stall),
    .div_done   (div_done),
    .div_result (div_result),
    .div_rd     (div_rd)
  );

  // Issue one op at edge T0 and wait for div_done; lat = edges after T0.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int stalls);
    res = 'x; rdo = 'x; lat = 0; stalls = 0;
    @(posedge clk); #1;
    div_op = op; rs1_val = a; rs2_val = b; rd_in = rd; div_start = 1'b1;
    @(negedge clk);
    if (div_stall) stalls++;
    @(posedge clk); #1;
    div_start = 1'b0;
    lat = 1;
    while (lat < 60) begin
      @(negedge clk);
      if (div_done) begin
        res = div_result;
        rdo = div_rd;
        break;
      end
      if (div_stall) stalls++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_vector(input string nm, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd,
                             input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          stalls;
    int          exp_stalls;
    exp_stalls = (exp_lat == 1) ? 1 : 33;
    run_op(op, a, b, rd, res, rdo, lat, stalls);
    checks++;
    if (res !== exp_res) begin
      failures++;
      $display("FAIL %s result got=%h exp=%h", nm, res, exp_res);
    end
    checks++;
    if (rdo !== rd) begin
      failures++;
      $display("FAIL %s rd got=%0d exp=%0d", nm, rdo, rd);
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", nm, lat, exp_lat);
    end
    checks++;
    if (stalls !== exp_stalls) begin
      failures++;
      $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, stalls, exp_stalls);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({div_busy, div_done, div_stall} !== 3'b000 || div_result !== 32'h0 || div_rd !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b stall=%b res=%h rd=%0d exp all zero",
               div_busy, div_done, div_stall, div_result, div_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    test_vector("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 33);
    test_vector("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd4, 32'd2, 33);
    test_vector("remu_fff9_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'd1, 33);
    test_vector("divu_fff9_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h7FFF_FFFC, 33);
    test_vector("divu_ffff_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'hFFFF_FFFF, 33);
    test_vector("divu_min_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 33);
    test_vector("remu_min_m1", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 33);
  endtask

  task automatic test_signed();
    test_vector("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
    test_vector("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
    test_vector("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 33);
    test_vector("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'd1, 33);
    test_vector("div_min_2", 3'b100, 32'h8000_0000, 32'd2, 5'd14, 32'hC000_0000, 33);
  endtask

  task automatic test_special();
    test_vector("div_5_0", 3'b100, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, 1);
    test_vector("rem_5_0", 3'b110, 32'd5, 32'd0, 5'd16, 32'd5, 1);
    test_vector("divu_0_0", 3'b101, 32'd0, 32'd0, 5'd17, 32'hFFFF_FFFF, 1);
    test_vector("div_min_m1", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1);
    test_vector("rem_min_m1", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0, 1);
  endtask

  task automatic test_hold();
    test_vector("hold_setup", 3'b101, 32'd77, 32'd7, 5'd20, 32'd11, 33);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (div_result !== 32'd11 || div_rd !== 5'd20 || div_done !== 1'b0 || div_busy !== 1'b0) begin
      failures++;
      $display("FAIL hold got res=%h rd=%0d done=%b busy=%b exp res=0000000b rd=20 done=0 busy=0",
               div_result, div_rd, div_done, div_busy);
    end
  endtask

  task automatic test_ignored_op();
    int seen;
    @(posedge clk); #1;
    div_op = 3'b000; rs1_val = 32'd9; rs2_val = 32'd3; div_start = 1'b1;
    @(negedge clk);
    checks++;
    if (div_stall !== 1'b0) begin
      failures++;
      $display("FAIL ignored_op_stall got=%b exp=0", div_stall);
    end
    div_op = 3'b011;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (div_busy || div_stall || div_done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL ignored_op_idle active_cycles got=%0d exp=0", seen);
    end
    @(posedge clk); #1;
    div_op = 3'b101; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (div_stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_start_stall got=%b exp=0", div_stall);
    end
    @(posedge clk); #1;
    div_start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_start_busy got=%b exp=0", div_busy);
    end
  endtask

  task automatic test_flush();
    int dones;
    @(posedge clk); #1;
    div_op = 3'b101; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd21; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b1 || div_done !== 1'b0) begin
      failures++;
      $display("FAIL flush_calc_cycle got busy=%b done=%b exp busy=1 done=0", div_busy, div_done);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b0 || div_stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_calc_idle got busy=%b stall=%b exp 0 0", div_busy, div_stall);
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL flush_calc_no_done got=%0d exp=0", dones);
    end
    test_vector("after_flush_divu_9_3", 3'b101, 32'd9, 32'd3, 5'd22, 32'd3, 33);

    // Flush landing on the DONE cycle must suppress the pulse.
    @(posedge clk); #1;
    div_op = 3'b100; rs1_val = 32'd5; rs2_val = 32'd0; rd_in = 5'd23; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (div_done !== 1'b0 || div_busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_done_cycle got done=%b busy=%b exp done=0 busy=1", div_done, div_busy);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b0 || div_done !== 1'b0) begin
      failures++;
      $display("FAIL flush_done_idle got busy=%b done=%b exp 0 0", div_busy, div_done);
    end
  endtask

  task automatic test_rst_mid();
    int dones;
    @(posedge clk); #1;
    div_op = 3'b101; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd24; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({div_busy, div_done, div_stall} !== 3'b000 || div_result !== 32'h0 || div_rd !== 5'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got busy=%b done=%b stall=%b res=%h rd=%0d exp all zero",
               div_busy, div_done, div_stall, div_result, div_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL rst_mid_no_done got=%0d exp=0", dones);
    end
  endtask

  task automatic test_held_start();
    int          dones;
    logic [31:0] res;
    @(posedge clk); #1;
    div_op = 3'b101; rs1_val = 32'd50; rs2_val = 32'd5; rd_in = 5'd25; div_start = 1'b1;
    dones = 0;
    res = 'x;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (div_done) begin
        dones++;
        res = div_result;
      end
      @(posedge clk); #1;
      if (i == 20) div_start = 1'b0;
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL held_start_pulses got=%0d exp=1", dones);
    end
    checks++;
    if (res !== 32'd10) begin
      failures++;
      $display("FAIL held_start_result got=%h exp=0000000a", res);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_hold();
    test_ignored_op();
    test_flush();
    test_rst_mid();
    test_held_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
